ibex_ex_dispatch: RTL and testbench

Issue-side counterpart of the execution block. Accepts one decoded ALU or MUL/DIV operation per handshake and registers it. Drives the execution block's operand, operator and enable inputs, and owns the two 34-bit intermediate-value registers that the ALU and multiplier/divider write back into. Waits for the execution block's valid, then holds the result for writeback under a valid/ready handshake.

---
 rtl/ibex_pkg.sv | 53 +++++
 rtl/ibex_ex_imd_regs.sv | 40 ++++
 rtl/ibex_ex_dispatch.sv | 207 ++++++++++++++++++++
 tb/tb_ibex_ex_dispatch.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_pkg
// Description : Shared types for the execute-dispatch slice: M-extension
//               variants, ALU / MUL-DIV operator encodings, dispatch FSM
//               states and intermediate-value register geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_pkg;

    typedef enum integer {
        RV32MNone        = 0,
        RV32MSlow        = 1,
        RV32MFast        = 2,
        RV32MSingleCycle = 3
    } rv32m_e;

    typedef enum logic [6:0] {
        ALU_ADD  = 7'd0,
        ALU_SUB  = 7'd1,
        ALU_XOR  = 7'd2,
        ALU_OR   = 7'd3,
        ALU_AND  = 7'd4,
        ALU_SLL  = 7'd5,
        ALU_SRL  = 7'd6,
        ALU_SRA  = 7'd7,
        ALU_SLT  = 7'd8,
        ALU_SLTU = 7'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ExDispIdle = 2'd0,
        ExDispExec = 2'd1,
        ExDispWb   = 2'd2
    } ex_disp_state_e;

    localparam int IMD_W   = 34;
    localparam int NUM_IMD = 2;

    // True when the configured M-extension variant has a multiplier/divider.
    function automatic logic md_present(input rv32m_e variant);
        return variant != RV32MNone;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_ex_imd_regs.sv
`default_nettype none
// ============================================================================
// Module      : ibex_ex_imd_regs
// Description : Two 34-bit intermediate-value lanes written back by the ALU
//               and multiplier/divider. Each lane has its own write enable;
//               all writes are qualified by en_i (EXEC and not aborted).
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_ex_imd_regs
    import ibex_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [NUM_IMD-1:0]   we_i,
    input  logic [IMD_W-1:0]     d_i [NUM_IMD],
    output logic [IMD_W-1:0]     q_o [NUM_IMD]
);

    logic [NUM_IMD-1:0][IMD_W-1:0] val_q;

    // Per-lane load; lanes are not cleared between ops, only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q <= '0;
        end else begin
            for (int k = 0; k < NUM_IMD; k++) begin
                if (en_i && we_i[k]) begin
                    val_q[k] <= d_i[k];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_IMD; k++) begin : g_out
        assign q_o[k] = val_q[k];
    end

endmodule
`default_nettype wire

// File: rtl/ibex_ex_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : ibex_ex_dispatch
// Description : Issue-side front end of the execution block. Registers one
//               ALU or MUL/DIV op per handshake, drives the EX operand /
//               operator / enable inputs while the op executes, owns the
//               intermediate-value registers and presents the result under a
//               valid/ready writeback handshake.
//               Optional feature macro: IBEX_EX_DISPATCH_FLUSH_EN adds a
//               flush_i abort input.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_ex_dispatch
    import ibex_pkg::*;
#(
    parameter rv32m_e RV32M = RV32MFast
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  alu_op_e            issue_alu_op_i,
    input  md_op_e             issue_md_op_i,
    input  logic               issue_mult_i,
    input  logic               issue_div_i,
    input  logic [1:0]         issue_signed_mode_i,
    input  logic [31:0]        issue_operand_a_i,
    input  logic [31:0]        issue_operand_b_i,
    input  logic [4:0]         issue_rd_i,

    output alu_op_e            alu_operator_o,
    output logic [31:0]        alu_operand_a_o,
    output logic [31:0]        alu_operand_b_o,
    output logic               alu_instr_first_cycle_o,

    output md_op_e             multdiv_operator_o,
    output logic [1:0]         multdiv_signed_mode_o,
    output logic [31:0]        multdiv_operand_a_o,
    output logic [31:0]        multdiv_operand_b_o,
    output logic               mult_en_o,
    output logic               div_en_o,
    output logic               mult_sel_o,
    output logic               div_sel_o,
    output logic               multdiv_ready_id_o,

    output logic [IMD_W-1:0]   imd_val_q_o [NUM_IMD],
    input  logic [NUM_IMD-1:0] imd_val_we_i,
    input  logic [IMD_W-1:0]   imd_val_d_i [NUM_IMD],

    input  logic [31:0]        result_ex_i,
    input  logic               ex_valid_i,

    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [4:0]         wb_rd_o,
    output logic [31:0]        wb_data_o,

`ifdef IBEX_EX_DISPATCH_FLUSH_EN
    input  logic               flush_i,
`endif
    output logic               busy_o
);

    localparam logic MD_EN = md_present(RV32M);

    ex_disp_state_e state_q, state_d;

    alu_op_e     alu_op_q;
    md_op_e      md_op_q;
    logic        mult_q, div_q, first_q;
    logic [1:0]  signed_q;
    logic [31:0] opa_q, opb_q, result_q;
    logic [4:0]  rd_q;

    logic in_exec;
    logic abort;
    logic issue_xfer;
    logic capture;

`ifdef IBEX_EX_DISPATCH_FLUSH_EN
    assign abort = flush_i;
`else
    assign abort = 1'b0;
`endif

    assign in_exec    = (state_q == ExDispExec);
    assign issue_xfer = issue_valid_i & issue_ready_o;
    assign capture    = in_exec & ex_valid_i & ~abort;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ExDispIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; an abort wins over every transition.
    always_comb begin
        state_d       = state_q;
        issue_ready_o = 1'b0;
        wb_valid_o    = 1'b0;
        case (state_q)
            ExDispIdle: begin
                issue_ready_o = 1'b1;
                if (issue_valid_i) begin
                    state_d = ExDispExec;
                end
            end
            ExDispExec: begin
                if (ex_valid_i) begin
                    state_d = ExDispWb;
                end
            end
            ExDispWb: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    issue_ready_o = 1'b1;
                    state_d       = issue_valid_i ? ExDispExec : ExDispIdle;
                end
            end
            default: begin
                state_d = ExDispIdle;
            end
        endcase
        if (abort) begin
            state_d       = ExDispIdle;
            issue_ready_o = 1'b0;
        end
    end

    // Latched op fields; M-extension flags are dropped when no multdiv exists.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_op_q <= ALU_ADD;
            md_op_q  <= MD_OP_MULL;
            mult_q   <= 1'b0;
            div_q    <= 1'b0;
            signed_q <= 2'b00;
            opa_q    <= '0;
            opb_q    <= '0;
            rd_q     <= '0;
        end else if (issue_xfer) begin
            alu_op_q <= issue_alu_op_i;
            md_op_q  <= issue_md_op_i;
            mult_q   <= issue_mult_i & MD_EN;
            div_q    <= issue_div_i & MD_EN;
            signed_q <= issue_signed_mode_i;
            opa_q    <= issue_operand_a_i;
            opb_q    <= issue_operand_b_i;
            rd_q     <= issue_rd_i;
        end
    end

    // First-cycle flag: set on accept, cleared once an EXEC cycle has passed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            first_q <= 1'b0;
        end else if (issue_xfer) begin
            first_q <= 1'b1;
        end else if (in_exec) begin
            first_q <= 1'b0;
        end
    end

    // Result capture on EX valid while executing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
        end else if (capture) begin
            result_q <= result_ex_i;
        end
    end

    ibex_ex_imd_regs u_imd_regs (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (in_exec & ~abort),
        .we_i  (imd_val_we_i),
        .d_i   (imd_val_d_i),
        .q_o   (imd_val_q_o)
    );

    // Operands hold their latched values in every state to avoid toggling.
    assign alu_operator_o          = alu_op_q;
    assign alu_operand_a_o         = opa_q;
    assign alu_operand_b_o         = opb_q;
    assign alu_instr_first_cycle_o = in_exec & first_q;

    assign multdiv_operator_o      = md_op_q;
    assign multdiv_signed_mode_o   = signed_q;
    assign multdiv_operand_a_o     = opa_q;
    assign multdiv_operand_b_o     = opb_q;
    assign mult_en_o               = in_exec & mult_q;
    assign mult_sel_o              = in_exec & mult_q;
    assign div_en_o                = in_exec & div_q;
    assign div_sel_o               = in_exec & div_q;
    assign multdiv_ready_id_o      = in_exec;

    assign wb_rd_o                 = rd_q;
    assign wb_data_o               = result_q;
    assign busy_o                  = (state_q != ExDispIdle);

endmodule
`default_nettype wire

// File: tb/tb_ibex_ex_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_ex_dispatch
// Description : Self-checking bench for ibex_ex_dispatch. A RV32MFast
//               instance and a RV32MNone instance share all stimulus.
//               Expected values come from a transaction-level model of the
//               op lifecycle (accept, N exec cycles, stalled writeback).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_ex_dispatch;
    import ibex_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    alu_op_e     issue_alu_op_i;
    md_op_e      issue_md_op_i;
    logic        issue_mult_i, issue_div_i;
    logic [1:0]  issue_signed_mode_i;
    logic [31:0] issue_operand_a_i, issue_operand_b_i;
    logic [4:0]  issue_rd_i;
    logic [1:0]  imd_val_we_i;
    logic [33:0] imd_val_d_i [2];
    logic [31:0] result_ex_i;
    logic        ex_valid_i, wb_ready_i;
`ifdef IBEX_EX_DISPATCH_FLUSH_EN
    logic        flush_i;
`endif

    logic        issue_ready_o, alu_instr_first_cycle_o, mult_en_o, div_en_o;
    logic        mult_sel_o, div_sel_o, multdiv_ready_id_o, wb_valid_o, busy_o;
    alu_op_e     alu_operator_o;
    md_op_e      multdiv_operator_o;
    logic [1:0]  multdiv_signed_mode_o;
    logic [31:0] alu_operand_a_o, alu_operand_b_o, multdiv_operand_a_o, multdiv_operand_b_o;
    logic [33:0] imd_val_q_o [2];
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    logic        nm_issue_ready, nm_first, nm_mult_en, nm_div_en, nm_mult_sel, nm_div_sel;
    logic        nm_md_ready, nm_wb_valid, nm_busy;
    alu_op_e     nm_alu_operator;
    md_op_e      nm_md_operator;
    logic [1:0]  nm_signed;
    logic [31:0] nm_alu_a, nm_alu_b, nm_md_a, nm_md_b, nm_wb_data;
    logic [33:0] nm_imd [2];
    logic [4:0]  nm_wb_rd;

    int checks = 0;
    int failures = 0;
    logic [33:0] m_imd [2];

    always #5 clk_i = ~clk_i;

    ibex_ex_dispatch #(.RV32M(RV32MFast)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_alu_op_i(issue_alu_op_i), .issue_md_op_i(issue_md_op_i),
        .issue_mult_i(issue_mult_i), .issue_div_i(issue_div_i),
        .issue_signed_mode_i(issue_signed_mode_i),
        .issue_operand_a_i(issue_operand_a_i), .issue_operand_b_i(issue_operand_b_i),
        .issue_rd_i(issue_rd_i),
        .alu_operator_o(alu_operator_o), .alu_operand_a_o(alu_operand_a_o),
        .alu_operand_b_o(alu_operand_b_o), .alu_instr_first_cycle_o(alu_instr_first_cycle_o),
        .multdiv_operator_o(multdiv_operator_o), .multdiv_signed_mode_o(multdiv_signed_mode_o),
        .multdiv_operand_a_o(multdiv_operand_a_o), .multdiv_operand_b_o(multdiv_operand_b_o),
        .mult_en_o(mult_en_o), .div_en_o(div_en_o), .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
        .multdiv_ready_id_o(multdiv_ready_id_o),
        .imd_val_q_o(imd_val_q_o), .imd_val_we_i(imd_val_we_i), .imd_val_d_i(imd_val_d_i),
        .result_ex_i(result_ex_i), .ex_valid_i(ex_valid_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
`ifdef IBEX_EX_DISPATCH_FLUSH_EN
        .flush_i(flush_i),
`endif
        .busy_o(busy_o)
    );

    ibex_ex_dispatch #(.RV32M(RV32MNone)) dut_nm (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(nm_issue_ready),
        .issue_alu_op_i(issue_alu_op_i), .issue_md_op_i(issue_md_op_i),
        .issue_mult_i(issue_mult_i), .issue_div_i(issue_div_i),
        .issue_signed_mode_i(issue_signed_mode_i),
        .issue_operand_a_i(issue_operand_a_i), .issue_operand_b_i(issue_operand_b_i),
        .issue_rd_i(issue_rd_i),
        .alu_operator_o(nm_alu_operator), .alu_operand_a_o(nm_alu_a),
        .alu_operand_b_o(nm_alu_b), .alu_instr_first_cycle_o(nm_first),
        .multdiv_operator_o(nm_md_operator), .multdiv_signed_mode_o(nm_signed),
        .multdiv_operand_a_o(nm_md_a), .multdiv_operand_b_o(nm_md_b),
        .mult_en_o(nm_mult_en), .div_en_o(nm_div_en), .mult_sel_o(nm_mult_sel), .div_sel_o(nm_div_sel),
        .multdiv_ready_id_o(nm_md_ready),
        .imd_val_q_o(nm_imd), .imd_val_we_i(imd_val_we_i), .imd_val_d_i(imd_val_d_i),
        .result_ex_i(result_ex_i), .ex_valid_i(ex_valid_i),
        .wb_valid_o(nm_wb_valid), .wb_ready_i(wb_ready_i),
        .wb_rd_o(nm_wb_rd), .wb_data_o(nm_wb_data),
`ifdef IBEX_EX_DISPATCH_FLUSH_EN
        .flush_i(flush_i),
`endif
        .busy_o(nm_busy)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_quiet();
        issue_valid_i = 1'b0;
        issue_mult_i = 1'b0;
        issue_div_i = 1'b0;
        imd_val_we_i = 2'b00;
        ex_valid_i = 1'b0;
        wb_ready_i = 1'b0;
`ifdef IBEX_EX_DISPATCH_FLUSH_EN
        flush_i = 1'b0;
`endif
    endtask

    task automatic set_issue(input alu_op_e aop, input md_op_e mop, input logic m, input logic d,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        issue_valid_i = 1'b1;
        issue_alu_op_i = aop;
        issue_md_op_i = mop;
        issue_mult_i = m;
        issue_div_i = d;
        issue_signed_mode_i = 2'($urandom_range(0, 3));
        issue_operand_a_i = a;
        issue_operand_b_i = b;
        issue_rd_i = rd;
    endtask

    // One full op lifecycle: accept from IDLE, lat EXEC cycles with EX valid
    // on the last one, then stall cycles of writeback before the transfer.
    // fixed_imd writes {1,2} on the first EXEC cycle only; otherwise imd
    // writes are random every cycle (and must be ignored outside EXEC).
    task automatic run_op(input string tag, input alu_op_e aop, input md_op_e mop,
                          input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                          input int lat, input int stall, input bit fixed_imd);
        logic em, ed;
        em = m;
        ed = d;
        set_issue(aop, mop, m, d, a, b, rd);
        #1;
        checks++;
        if (issue_ready_o !== 1'b1) begin
            failures++; $display("FAIL %s idle_ready act=%0b exp=1", tag, issue_ready_o);
        end
        tick();
        issue_valid_i = 1'b0;
        for (int c = 0; c < lat; c++) begin
            if (fixed_imd) begin
                imd_val_we_i = (c == 0) ? 2'b11 : 2'b00;
                imd_val_d_i[0] = 34'h1;
                imd_val_d_i[1] = 34'h2;
            end else begin
                imd_val_we_i = 2'($urandom_range(0, 3));
                imd_val_d_i[0] = {2'($urandom), 32'($urandom)};
                imd_val_d_i[1] = {2'($urandom), 32'($urandom)};
            end
            ex_valid_i = (c == lat - 1);
            result_ex_i = (c == lat - 1) ? res : 32'($urandom);
            #1;
            checks++;
            if (alu_instr_first_cycle_o !== (c == 0)) begin
                failures++; $display("FAIL %s first c=%0d act=%0b exp=%0b", tag, c, alu_instr_first_cycle_o, c == 0);
            end
            checks++;
            if ({mult_en_o, mult_sel_o, div_en_o, div_sel_o, multdiv_ready_id_o, busy_o} !== {em, em, ed, ed, 2'b11}) begin
                failures++; $display("FAIL %s enables c=%0d act=%b exp=%b", tag, c,
                    {mult_en_o, mult_sel_o, div_en_o, div_sel_o, multdiv_ready_id_o, busy_o}, {em, em, ed, ed, 2'b11});
            end
            checks++;
            if ({alu_operand_a_o, alu_operand_b_o, multdiv_operand_a_o, multdiv_operand_b_o} !== {a, b, a, b}
                || alu_operator_o !== aop || multdiv_operator_o !== mop) begin
                failures++; $display("FAIL %s operands act=%h/%h op=%0d exp=%h/%h op=%0d", tag,
                    alu_operand_a_o, alu_operand_b_o, alu_operator_o, a, b, aop);
            end
            checks++;
            if ({wb_valid_o, issue_ready_o} !== 2'b00) begin
                failures++; $display("FAIL %s exec_hs act=%b exp=00", tag, {wb_valid_o, issue_ready_o});
            end
            checks++;
            if ({nm_mult_en, nm_mult_sel, nm_div_en, nm_div_sel} !== 4'b0000 || nm_alu_a !== a || nm_alu_operator !== aop) begin
                failures++; $display("FAIL %s nomul act=%b a=%h exp=0000 a=%h", tag,
                    {nm_mult_en, nm_mult_sel, nm_div_en, nm_div_sel}, nm_alu_a, a);
            end
            for (int k = 0; k < 2; k++) if (imd_val_we_i[k]) m_imd[k] = imd_val_d_i[k];
            tick();
        end
        ex_valid_i = 1'b0;
        imd_val_we_i = 2'b00;
        #1;
        checks++;
        if (imd_val_q_o[0] !== m_imd[0] || imd_val_q_o[1] !== m_imd[1]) begin
            failures++; $display("FAIL %s imd act=%h,%h exp=%h,%h", tag, imd_val_q_o[0], imd_val_q_o[1], m_imd[0], m_imd[1]);
        end
        for (int s = 0; s <= stall; s++) begin
            wb_ready_i = (s == stall);
            imd_val_we_i = 2'($urandom_range(0, 3));
            imd_val_d_i[0] = {2'($urandom), 32'($urandom)};
            imd_val_d_i[1] = {2'($urandom), 32'($urandom)};
            ex_valid_i = 1'($urandom);
            result_ex_i = 32'($urandom);
            #1;
            checks++;
            if (wb_valid_o !== 1'b1 || wb_data_o !== res || wb_rd_o !== rd) begin
                failures++; $display("FAIL %s wb s=%0d act=%0b %h r%0d exp=1 %h r%0d", tag, s, wb_valid_o, wb_data_o, wb_rd_o, res, rd);
            end
            checks++;
            if (issue_ready_o !== (s == stall) || {mult_en_o, div_en_o, alu_instr_first_cycle_o, multdiv_ready_id_o} !== 4'b0000) begin
                failures++; $display("FAIL %s wb_ctrl s=%0d ready act=%0b exp=%0b en=%b", tag, s, issue_ready_o, s == stall,
                    {mult_en_o, div_en_o, alu_instr_first_cycle_o, multdiv_ready_id_o});
            end
            checks++;
            if (nm_wb_data !== res) begin
                failures++; $display("FAIL %s nm_wb act=%h exp=%h", tag, nm_wb_data, res);
            end
            tick();
        end
        drive_quiet();
        #1;
        checks++;
        if ({busy_o, wb_valid_o} !== 2'b00 || imd_val_q_o[0] !== m_imd[0] || imd_val_q_o[1] !== m_imd[1]) begin
            failures++; $display("FAIL %s post_wb busy=%0b wbv=%0b imd=%h,%h exp imd=%h,%h", tag, busy_o, wb_valid_o,
                imd_val_q_o[0], imd_val_q_o[1], m_imd[0], m_imd[1]);
        end
    endtask

    task automatic test_reset();
        drive_quiet();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        m_imd[0] = '0;
        m_imd[1] = '0;
        #1;
        checks++;
        if ({busy_o, wb_valid_o, mult_en_o, div_en_o, alu_instr_first_cycle_o, multdiv_ready_id_o} !== 6'b0
            || alu_operand_a_o !== 32'h0 || wb_data_o !== 32'h0 || wb_rd_o !== 5'h0) begin
            failures++; $display("FAIL reset_outputs act busy=%0b wbv=%0b a=%h data=%h exp all 0", busy_o, wb_valid_o, alu_operand_a_o, wb_data_o);
        end
        checks++;
        if (imd_val_q_o[0] !== 34'h0 || imd_val_q_o[1] !== 34'h0) begin
            failures++; $display("FAIL reset_imd act=%h,%h exp=0,0", imd_val_q_o[0], imd_val_q_o[1]);
        end
        checks++;
        if (issue_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_ready act=%0b exp=1", issue_ready_o);
        end
    endtask

    task automatic test_alu_add();
        run_op("alu_add", ALU_ADD, MD_OP_MULL, 1'b0, 1'b0, 32'd5, 32'd7, 5'd3, 32'd12, 1, 0, 1'b0);
    endtask

    task automatic test_mul();
        run_op("mul", ALU_ADD, MD_OP_MULL, 1'b1, 1'b0, 32'd3, 32'd4, 5'd9, 32'd12, 3, 0, 1'b1);
        checks++;
        if (imd_val_q_o[0] !== 34'h1 || imd_val_q_o[1] !== 34'h2) begin
            failures++; $display("FAIL mul_imd act=%h,%h exp=1,2", imd_val_q_o[0], imd_val_q_o[1]);
        end
    endtask

    task automatic test_wb_hold();
        run_op("wb_hold", ALU_XOR, MD_OP_DIV, 1'b0, 1'b1, 32'hDEAD_0001, 32'h0000_0003, 5'd17, 32'hCAFE_F00D, 2, 4, 1'b0);
    endtask

    task automatic test_rv32m_none();
        run_op("rv32m_none", ALU_SUB, MD_OP_MULH, 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd30, 32'h0BAD_BEEF, 2, 1, 1'b0);
    endtask

    // Writeback transfer and a new issue in the same cycle: new op executes next.
    task automatic test_back_to_back();
        set_issue(ALU_AND, MD_OP_MULL, 1'b0, 1'b0, 32'h1111_0000, 32'h0000_2222, 5'd4);
        tick();
        issue_valid_i = 1'b0;
        ex_valid_i = 1'b1;
        result_ex_i = 32'hA5A5_0001;
        tick();
        ex_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_ready_i = 1'b1;
            set_issue(ALU_OR, MD_OP_MULL, 1'b0, 1'b0, 32'h100 + i, 32'h200 + i, 5'(10 + i));
            #1;
            checks++;
            if (issue_ready_o !== 1'b1 || wb_valid_o !== 1'b1) begin
                failures++; $display("FAIL b2b_wb_ready i=%0d act=%0b/%0b exp=1/1", i, issue_ready_o, wb_valid_o);
            end
            tick();
            issue_valid_i = 1'b0;
            wb_ready_i = 1'b0;
            ex_valid_i = 1'b1;
            result_ex_i = 32'hB000_0000 + i;
            #1;
            checks++;
            if (alu_instr_first_cycle_o !== 1'b1 || alu_operand_a_o !== 32'h100 + i || busy_o !== 1'b1 || wb_valid_o !== 1'b0) begin
                failures++; $display("FAIL b2b_exec i=%0d first=%0b a=%h wbv=%0b exp first=1 a=%h wbv=0", i,
                    alu_instr_first_cycle_o, alu_operand_a_o, wb_valid_o, 32'h100 + i);
            end
            tick();
            ex_valid_i = 1'b0;
            #1;
            checks++;
            if (wb_data_o !== 32'hB000_0000 + i || wb_rd_o !== 5'(10 + i)) begin
                failures++; $display("FAIL b2b_data i=%0d act=%h r%0d exp=%h r%0d", i, wb_data_o, wb_rd_o, 32'hB000_0000 + i, 10 + i);
            end
        end
        wb_ready_i = 1'b1;
        tick();
        drive_quiet();
    endtask

    task automatic test_reset_mid_div();
        set_issue(ALU_ADD, MD_OP_DIV, 1'b0, 1'b1, 32'd100, 32'd7, 5'd21);
        tick();
        issue_valid_i = 1'b0;
        imd_val_we_i = 2'b11;
        imd_val_d_i[0] = 34'h2_1234_5678;
        imd_val_d_i[1] = 34'h1_8765_4321;
        tick();
        imd_val_we_i = 2'b00;
        #1;
        checks++;
        if (div_en_o !== 1'b1 || imd_val_q_o[0] !== 34'h2_1234_5678) begin
            failures++; $display("FAIL div_pre_reset div_en=%0b imd0=%h exp 1 212345678", div_en_o, imd_val_q_o[0]);
        end
        rst_i = 1'b1;
        ex_valid_i = 1'b1;
        result_ex_i = 32'hFFFF_FFFF;
        imd_val_we_i = 2'b11;
        tick();
        rst_i = 1'b0;
        drive_quiet();
        m_imd[0] = '0;
        m_imd[1] = '0;
        #1;
        checks++;
        if ({busy_o, div_en_o, div_sel_o, wb_valid_o, multdiv_ready_id_o} !== 5'b0 || multdiv_operand_a_o !== 32'h0
            || multdiv_signed_mode_o !== 2'b00 || wb_data_o !== 32'h0 || wb_rd_o !== 5'h0) begin
            failures++; $display("FAIL div_reset act busy=%0b div=%0b a=%h data=%h exp all 0", busy_o, div_en_o, multdiv_operand_a_o, wb_data_o);
        end
        checks++;
        if (imd_val_q_o[0] !== 34'h0 || imd_val_q_o[1] !== 34'h0) begin
            failures++; $display("FAIL div_reset_imd act=%h,%h exp=0,0", imd_val_q_o[0], imd_val_q_o[1]);
        end
    endtask

`ifdef IBEX_EX_DISPATCH_FLUSH_EN
    task automatic test_flush();
        set_issue(ALU_ADD, MD_OP_MULL, 1'b1, 1'b0, 32'd9, 32'd9, 5'd1);
        tick();
        issue_valid_i = 1'b1;
        flush_i = 1'b1;
        imd_val_we_i = 2'b11;
        imd_val_d_i[0] = 34'h3_0000_0001;
        imd_val_d_i[1] = 34'h3_0000_0002;
        ex_valid_i = 1'b1;
        #1;
        checks++;
        if (issue_ready_o !== 1'b0) begin
            failures++; $display("FAIL flush_ready act=%0b exp=0", issue_ready_o);
        end
        tick();
        drive_quiet();
        #1;
        checks++;
        if ({busy_o, wb_valid_o} !== 2'b00 || imd_val_q_o[0] !== m_imd[0] || imd_val_q_o[1] !== m_imd[1]) begin
            failures++; $display("FAIL flush_exec busy=%0b wbv=%0b imd=%h,%h exp 0 0 %h,%h", busy_o, wb_valid_o,
                imd_val_q_o[0], imd_val_q_o[1], m_imd[0], m_imd[1]);
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic m, d;
            kind = $urandom_range(0, 2);
            m = (kind == 1);
            d = (kind == 2);
            run_op("random", alu_op_e'(7'($urandom_range(0, 9))), md_op_e'(2'($urandom)), m, d,
                   32'($urandom), 32'($urandom), 5'($urandom), 32'($urandom),
                   $urandom_range(1, 4), $urandom_range(0, 3), 1'b0);
        end
    endtask

    initial begin
        issue_alu_op_i = ALU_ADD;
        issue_md_op_i = MD_OP_MULL;
        issue_signed_mode_i = 2'b00;
        issue_operand_a_i = '0;
        issue_operand_b_i = '0;
        issue_rd_i = '0;
        imd_val_d_i[0] = '0;
        imd_val_d_i[1] = '0;
        result_ex_i = '0;
        test_reset();
        test_alu_add();
        test_mul();
        test_wb_hold();
        test_back_to_back();
        test_rv32m_none();
        test_reset_mid_div();
`ifdef IBEX_EX_DISPATCH_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
